// File: rtl/tage_tn.sv
// tage_tn: tagged TAGE component table with init sweep, RMW update and useful-bit aging
module tage_tn #(
    parameter int PC_WIDTH       = 32,
    parameter int PC_SHIFT       = 2,
    parameter int INDEX_BITS     = 7,
    parameter int TAG_BITS       = 8,
    parameter int CTR_BITS       = 3,
    parameter int U_BITS         = 2,
    parameter int HIST_LEN       = 16,
    parameter int U_RESET_PERIOD = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                lookup_valid,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    input  logic [HIST_LEN-1:0] lookup_ghist,
    output logic                pred_valid,
    output logic                pred_hit,
    output logic [CTR_BITS-1:0] pred_ctr,
    output logic                pred_taken,
    input  logic                update_valid,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic [HIST_LEN-1:0] update_ghist,
    input  logic                update_taken,
    input  logic                update_alloc,
    input  logic                update_u_valid,
    input  logic                update_u_inc,
    output logic                alloc_ok,
    output logic                alloc_fail
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WN = CTR_WT - 1'b1;
    localparam logic [31:0] AGE_LAST = 32'(U_RESET_PERIOD - 1);

    logic [0:0]            state;
    logic [INDEX_BITS-1:0] ptr;
    logic [31:0]           age_cnt;
    logic                  age_phase;

    logic                  v_mem   [ENTRIES];
    logic [TAG_BITS-1:0]   tag_mem [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_mem [ENTRIES];
    logic [U_BITS-1:0]     u_mem   [ENTRIES];

    function automatic logic [31:0] fold(input logic [HIST_LEN-1:0] h, input int w);
        fold = '0;
        for (int i = 0; i < HIST_LEN; i++) fold[i % w] = fold[i % w] ^ h[i];
    endfunction

    function automatic logic [INDEX_BITS-1:0] hash_idx(input logic [PC_WIDTH-1:0] pc, input logic [HIST_LEN-1:0] h);
        hash_idx = pc[PC_SHIFT +: INDEX_BITS] ^ INDEX_BITS'(fold(h, INDEX_BITS));
    endfunction

    function automatic logic [TAG_BITS-1:0] hash_tag(input logic [PC_WIDTH-1:0] pc, input logic [HIST_LEN-1:0] h);
        hash_tag = pc[PC_SHIFT + INDEX_BITS +: TAG_BITS] ^ TAG_BITS'(fold(h, TAG_BITS)) ^ TAG_BITS'(fold(h, TAG_BITS - 1) << 1);
    endfunction

    logic [INDEX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0]   l_tag, u_tag, e_tag;
    logic [CTR_BITS-1:0]   l_ctr, e_ctr, upd_ctr;
    logic [U_BITS-1:0]     e_u, upd_u, age_mask;
    logic                  l_hit, e_v, u_hit, do_upd, do_alloc, alloc_win, age_fire;

    assign ready     = state == RUN;
    assign l_idx     = hash_idx(lookup_pc, lookup_ghist);
    assign l_tag     = hash_tag(lookup_pc, lookup_ghist);
    assign u_idx     = hash_idx(update_pc, update_ghist);
    assign u_tag     = hash_tag(update_pc, update_ghist);
    assign l_ctr     = ctr_mem[l_idx];
    assign l_hit     = lookup_valid && ready && v_mem[l_idx] && tag_mem[l_idx] == l_tag;
    assign e_v       = v_mem[u_idx];
    assign e_tag     = tag_mem[u_idx];
    assign e_ctr     = ctr_mem[u_idx];
    assign e_u       = u_mem[u_idx];
    assign u_hit     = e_v && e_tag == u_tag;
    assign do_upd    = update_valid && ready;
    assign do_alloc  = !u_hit && update_alloc;
    assign alloc_win = do_alloc && e_u == '0;
    assign age_fire  = do_upd && age_cnt == AGE_LAST;
    assign age_mask  = age_fire ? (age_phase ? U_BITS'(1) : U_BITS'(1) << (U_BITS - 1)) : '0;

    // next counter and useful values for the entry selected by the update
    always_comb begin
        upd_ctr = u_hit ? (update_taken ? (e_ctr == '1 ? e_ctr : e_ctr + 1'b1) : (e_ctr == '0 ? e_ctr : e_ctr - 1'b1))
                : alloc_win ? (update_taken ? CTR_WT : CTR_WN) : e_ctr;
        upd_u   = (u_hit && update_u_valid) ? (update_u_inc ? (e_u == '1 ? e_u : e_u + 1'b1) : (e_u == '0 ? e_u : e_u - 1'b1))
                : (do_alloc && e_u != '0) ? e_u - 1'b1 : e_u;
    end

    // control state, registered lookup result, allocation pulses and aging counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            ptr        <= '0;
            age_cnt    <= '0;
            age_phase  <= 1'b0;
            pred_valid <= 1'b0;
            pred_hit   <= 1'b0;
            pred_ctr   <= '0;
            pred_taken <= 1'b0;
            alloc_ok   <= 1'b0;
            alloc_fail <= 1'b0;
        end else begin
            if (state == INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == '1) state <= RUN;
            end
            pred_valid <= lookup_valid && ready;
            pred_hit   <= l_hit;
            pred_ctr   <= l_hit ? l_ctr : '0;
            pred_taken <= l_hit && l_ctr[CTR_BITS-1];
            alloc_ok   <= do_upd && alloc_win;
            alloc_fail <= do_upd && do_alloc && e_u != '0;
            if (do_upd) begin
                age_cnt <= age_fire ? '0 : age_cnt + 1'b1;
                if (age_fire) age_phase <= !age_phase;
            end
        end
    end

    // table storage: init sweep clears one entry per cycle, run mode applies the update then the aging clear
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            v_mem[ptr]   <= 1'b0;
            tag_mem[ptr] <= '0;
            ctr_mem[ptr] <= '0;
            u_mem[ptr]   <= '0;
        end else if (do_upd) begin
            v_mem[u_idx]   <= e_v || alloc_win;
            tag_mem[u_idx] <= alloc_win ? u_tag : e_tag;
            ctr_mem[u_idx] <= upd_ctr;
            for (int i = 0; i < ENTRIES; i++)
                u_mem[i] <= (INDEX_BITS'(i) == u_idx ? upd_u : u_mem[i]) & ~age_mask;
        end
    end
endmodule

// File: tb/tb_tage_tn.sv
// tb_tage_tn: directed self-checking bench for the tagged TAGE table
module tb_tage_tn;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic [15:0] lookup_ghist = '0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [2:0]  pred_ctr;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic [15:0] update_ghist = '0;
    logic        update_taken = 1'b0, update_alloc = 1'b0, update_u_valid = 1'b0, update_u_inc = 1'b0;
    logic        alloc_ok, alloc_fail;
    int          checks = 0;
    int          errors = 0;

    tage_tn #(.U_RESET_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ghist(lookup_ghist),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
        .update_valid(update_valid), .update_pc(update_pc), .update_ghist(update_ghist),
        .update_taken(update_taken), .update_alloc(update_alloc),
        .update_u_valid(update_u_valid), .update_u_inc(update_u_inc),
        .alloc_ok(alloc_ok), .alloc_fail(alloc_fail)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [15:0] gh, input logic tk, input logic al, input logic uv, input logic ui);
        update_valid = 1'b1; update_pc = pc; update_ghist = gh;
        update_taken = tk; update_alloc = al; update_u_valid = uv; update_u_inc = ui;
        step();
        update_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic [15:0] gh);
        lookup_valid = 1'b1; lookup_pc = pc; lookup_ghist = gh;
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic do_reset();
        int n = 0;
        rst_n = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
        step();
        step();
        checks++;
        if ({ready, pred_valid, pred_hit, alloc_ok, alloc_fail} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 00000", {ready, pred_valid, pred_hit, alloc_ok, alloc_fail});
        end
        rst_n = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h100; lookup_ghist = '0;
        while (!ready && n < 200) begin
            step();
            n++;
            if (!ready) begin
                checks++;
                if (pred_valid !== 1'b0) begin errors++; $display("FAIL init_pred_valid: got %b want 0 at cycle %0d", pred_valid, n); end
            end
        end
        lookup_valid = 1'b0;
        checks++;
        if (n !== 128) begin errors++; $display("FAIL init_cycles: got %0d want 128", n); end
    endtask

    task automatic test_reset();
        do_reset();
        look(32'h100, 16'h0);
        checks++;
        if ({pred_valid, pred_hit, pred_ctr} !== 5'b10000) begin
            errors++; $display("FAIL reset_lookup: got valid=%b hit=%b ctr=%0d want 1 0 0", pred_valid, pred_hit, pred_ctr);
        end
    endtask

    task automatic test_alloc();
        upd(32'h100, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b10) begin errors++; $display("FAIL alloc_pulse: got ok=%b fail=%b want 1 0", alloc_ok, alloc_fail); end
        look(32'h100, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr, pred_taken} !== 5'b11001) begin
            errors++; $display("FAIL alloc_lookup: got hit=%b ctr=%b taken=%b want 1 100 1", pred_hit, pred_ctr, pred_taken);
        end
        checks++;
        if (alloc_ok !== 1'b0) begin errors++; $display("FAIL alloc_pulse_width: got %b want 0", alloc_ok); end
    endtask

    task automatic test_ctr();
        repeat (4) upd(32'h100, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b00) begin errors++; $display("FAIL hit_ignores_alloc: got ok=%b fail=%b want 0 0", alloc_ok, alloc_fail); end
        look(32'h100, 16'h0);
        checks++;
        if (pred_ctr !== 3'b111) begin errors++; $display("FAIL ctr_sat_high: got %b want 111", pred_ctr); end
        repeat (5) upd(32'h100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        look(32'h100, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr, pred_taken} !== 5'b10100) begin
            errors++; $display("FAIL ctr_down: got hit=%b ctr=%b taken=%b want 1 010 0", pred_hit, pred_ctr, pred_taken);
        end
    endtask

    task automatic test_useful();
        upd(32'h100, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        upd(32'h300, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b01) begin errors++; $display("FAIL alloc_refused: got ok=%b fail=%b want 0 1", alloc_ok, alloc_fail); end
        look(32'h100, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr} !== 4'b1011) begin errors++; $display("FAIL victim_kept: got hit=%b ctr=%b want 1 011", pred_hit, pred_ctr); end
        upd(32'h300, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b10) begin errors++; $display("FAIL alloc_second: got ok=%b fail=%b want 1 0", alloc_ok, alloc_fail); end
        look(32'h300, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr} !== 4'b1100) begin errors++; $display("FAIL new_entry: got hit=%b ctr=%b want 1 100", pred_hit, pred_ctr); end
        look(32'h100, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr, pred_taken} !== 5'b00000) begin errors++; $display("FAIL old_evicted: got hit=%b ctr=%b want 0 000", pred_hit, pred_ctr); end
        upd(32'h500, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b00) begin errors++; $display("FAIL miss_no_alloc: got ok=%b fail=%b want 0 0", alloc_ok, alloc_fail); end
        look(32'h300, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr} !== 4'b1100) begin errors++; $display("FAIL miss_untouched: got hit=%b ctr=%b want 1 100", pred_hit, pred_ctr); end
    endtask

    task automatic test_aging();
        do_reset();
        upd(32'h100, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) upd(32'h100, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) upd(32'h100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        upd(32'h300, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b01) begin errors++; $display("FAIL age_even_u1: got ok=%b fail=%b want 0 1", alloc_ok, alloc_fail); end
        upd(32'h300, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b10) begin errors++; $display("FAIL age_even_u0: got ok=%b fail=%b want 1 0", alloc_ok, alloc_fail); end
        do_reset();
        upd(32'h100, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) upd(32'h100, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (12) upd(32'h100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        upd(32'h300, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b10) begin errors++; $display("FAIL age_odd_u0: got ok=%b fail=%b want 1 0", alloc_ok, alloc_fail); end
        upd(32'h300, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (5) upd(32'h300, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        upd(32'h300, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        upd(32'h100, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({alloc_ok, alloc_fail} !== 2'b10) begin errors++; $display("FAIL age_with_inc: got ok=%b fail=%b want 1 0", alloc_ok, alloc_fail); end
    endtask

    task automatic test_reset_mid();
        look(32'h100, 16'h0);
        checks++;
        if ({pred_valid, pred_hit} !== 2'b11) begin errors++; $display("FAIL pre_reset_hit: got valid=%b hit=%b want 1 1", pred_valid, pred_hit); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, pred_valid, pred_hit} !== 3'b000) begin errors++; $display("FAIL async_reset: got %b want 000", {ready, pred_valid, pred_hit}); end
        do_reset();
        look(32'h100, 16'h0);
        checks++;
        if ({pred_valid, pred_hit} !== 2'b10) begin errors++; $display("FAIL reinit_miss: got valid=%b hit=%b want 1 0", pred_valid, pred_hit); end
    endtask

    task automatic test_back_to_back();
        upd(32'h100, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        lookup_valid = 1'b1; lookup_pc = 32'h100; lookup_ghist = '0;
        upd(32'h100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup_valid = 1'b0;
        checks++;
        if ({pred_hit, pred_ctr} !== 4'b1100) begin errors++; $display("FAIL read_before_write: got hit=%b ctr=%b want 1 100", pred_hit, pred_ctr); end
        look(32'h100, 16'h0);
        checks++;
        if (pred_ctr !== 3'b101) begin errors++; $display("FAIL after_write: got %b want 101", pred_ctr); end
    endtask

    task automatic test_hash();
        upd(32'h100, 16'h0081, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (alloc_ok !== 1'b1) begin errors++; $display("FAIL hash_alloc: got %b want 1", alloc_ok); end
        look(32'h10300, 16'h0);
        checks++;
        if ({pred_hit, pred_ctr, pred_taken} !== 5'b10110) begin errors++; $display("FAIL hash_alias: got hit=%b ctr=%b want 1 011", pred_hit, pred_ctr); end
        look(32'h100, 16'h0081);
        checks++;
        if ({pred_hit, pred_ctr} !== 4'b1011) begin errors++; $display("FAIL hash_same: got hit=%b ctr=%b want 1 011", pred_hit, pred_ctr); end
        look(32'h100, 16'h0);
        checks++;
        if (pred_hit !== 1'b0) begin errors++; $display("FAIL hash_replaced: got %b want 0", pred_hit); end
        look(32'h100, 16'h0001);
        checks++;
        if (pred_hit !== 1'b0) begin errors++; $display("FAIL hash_other_idx: got %b want 0", pred_hit); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_ctr();
        test_useful();
        test_aging();
        test_reset_mid();
        test_back_to_back();
        test_hash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
